// File: rtl/stopwatch_pkg.sv
// Shared types and defaults for the stopwatch controller slice.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_t;

    // 200 ms key lockout and 10 ms tick at a 50 MHz clock
    localparam int unsigned DEFAULT_DELAY_TIME = 10000000;
    localparam int unsigned DEFAULT_TICK_DIV   = 500000;

    localparam int unsigned LOCK_W = 32;

endpackage

// File: rtl/stopwatch_if.sv
// Pushbutton inputs and control/status outputs of the stopwatch controller.
interface stopwatch_if;

    logic       key_reset;
    logic       key_start_pause;
    logic       key_display_stop;
    logic       tick_en;
    logic       clr;
    logic       latch_en;
    logic [1:0] state;
    logic       led0;
    logic       led1;
    logic       led2;
    logic       led3;

    // Board side: drives the keys, observes the controller
    modport master (
        output key_reset, key_start_pause, key_display_stop,
        input  tick_en, clr, latch_en, state, led0, led1, led2, led3
    );

    // Controller side
    modport slave (
        input  key_reset, key_start_pause, key_display_stop,
        output tick_en, clr, latch_en, state, led0, led1, led2, led3
    );

endinterface

// File: rtl/stopwatch_ctrl_key_debounce.sv
// Pushbutton conditioning: 2-flop synchroniser, falling-edge detector and a
// lockout counter that rejects further edges until DELAY_TIME cycles pass.
module key_debounce
    import stopwatch_pkg::*;
#(
    parameter int unsigned DELAY_TIME = DEFAULT_DELAY_TIME
) (
    input  logic clk,
    input  logic reset,
    input  logic key_i,
    output logic press_o
);

    localparam logic [LOCK_W-1:0] DELAY_LIM = LOCK_W'(DELAY_TIME);

    logic              sync1_q;
    logic              sync2_q;
    logic              prev_q;
    logic [LOCK_W-1:0] lock_q;
    logic [LOCK_W-1:0] lock_d;
    logic              press_q;
    logic              press_d;

    // An edge is accepted only once the lockout has fully expired; acceptance
    // restarts the lockout, otherwise the counter climbs and saturates.
    always_comb begin
        press_d = 1'b0;
        lock_d  = lock_q;
        if (prev_q && !sync2_q && (lock_q >= DELAY_LIM)) begin
            press_d = 1'b1;
            lock_d  = '0;
        end else if (lock_q < DELAY_LIM) begin
            lock_d = lock_q + 1'b1;
        end
    end

    // Synchroniser, edge history, lockout counter and registered press pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            lock_q  <= DELAY_LIM;
            press_q <= 1'b0;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            lock_q  <= lock_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: run/pause/idle FSM, 10 ms prescaler, display freeze
// flag and status LEDs. The BCD counters live elsewhere and follow
// tick_en/clr/latch_en.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned DELAY_TIME = DEFAULT_DELAY_TIME,
    parameter int unsigned TICK_DIV   = DEFAULT_TICK_DIV
) (
    input  logic       clk,
    input  logic       reset,
    stopwatch_if.slave sw
);

    localparam int unsigned       CNT_W     = 32;
    localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);

    logic             pressReset;
    logic             pressStart;
    logic             pressDisplay;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] presc_q;
    logic [CNT_W-1:0] presc_d;
    logic             frozen_q;
    logic             frozen_d;
    logic             tick_q;
    logic             tick_d;
    logic             clr_q;
    logic             clr_d;
    logic             latch_q;
    logic [3:0]       led_q;

    key_debounce #(.DELAY_TIME(DELAY_TIME)) uKeyReset (
        .clk     (clk),
        .reset   (reset),
        .key_i   (sw.key_reset),
        .press_o (pressReset)
    );

    key_debounce #(.DELAY_TIME(DELAY_TIME)) uKeyStart (
        .clk     (clk),
        .reset   (reset),
        .key_i   (sw.key_start_pause),
        .press_o (pressStart)
    );

    key_debounce #(.DELAY_TIME(DELAY_TIME)) uKeyDisplay (
        .clk     (clk),
        .reset   (reset),
        .key_i   (sw.key_display_stop),
        .press_o (pressDisplay)
    );

    // Next state: the reset key overrides everything; in RUN the prescaler
    // keeps counting on the pause cycle so a wrap there still yields its tick.
    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        frozen_d = frozen_q;
        tick_d   = 1'b0;
        clr_d    = 1'b0;
        if (pressReset) begin
            state_d  = IDLE;
            presc_d  = '0;
            frozen_d = 1'b0;
            clr_d    = 1'b1;
        end else begin
            if (state_q == RUN) begin
                tick_d  = (presc_q == TICK_LAST);
                presc_d = (presc_q == TICK_LAST) ? '0 : presc_q + 1'b1;
            end else if (state_q == IDLE) begin
                presc_d = '0;
            end
            case (state_q)
                IDLE:    if (pressStart) state_d = RUN;
                RUN:     if (pressStart) state_d = PAUSE;
                PAUSE:   if (pressStart) state_d = RUN;
                default: state_d = IDLE;
            endcase
            if (pressDisplay && (state_q != IDLE)) begin
                frozen_d = ~frozen_q;
            end
        end
    end

    // State, prescaler and every output are registered from the next values
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            presc_q  <= '0;
            frozen_q <= 1'b0;
            tick_q   <= 1'b0;
            clr_q    <= 1'b1;
            latch_q  <= 1'b1;
            led_q    <= 4'b1000;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            frozen_q <= frozen_d;
            tick_q   <= tick_d;
            clr_q    <= clr_d;
            latch_q  <= ~frozen_d;
            led_q    <= {state_d == IDLE, frozen_d, state_d == PAUSE, state_d == RUN};
        end
    end

    assign sw.state    = state_q;
    assign sw.tick_en  = tick_q;
    assign sw.clr      = clr_q;
    assign sw.latch_en = latch_q;
    assign sw.led0     = led_q[0];
    assign sw.led1     = led_q[1];
    assign sw.led2     = led_q[2];
    assign sw.led3     = led_q[3];

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DELAY_TIME=8, TICK_DIV=5.
// Edges are numbered from 1; every check is made 1 time unit after the
// named edge, and inputs changed there are first sampled on the next edge.
module tb_stopwatch_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   edgeNum;

    stopwatch_if sw ();

    stopwatch_ctrl #(
        .DELAY_TIME (8),
        .TICK_DIV   (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sw    (sw)
    );

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic rst, input logic kr, input logic ks, input logic kd);
        reset               = rst;
        sw.key_reset        = kr;
        sw.key_start_pause  = ks;
        sw.key_display_stop = kd;
    endtask

    task automatic stepTo(input int n);
        while (edgeNum < n) begin
            @(posedge clk);
            edgeNum++;
        end
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s @edge %0d observed=%0h expected=%0h", tag, edgeNum, observed, expected);
        end
    endtask

    task automatic checkState(input string tag, input logic [1:0] expected);
        checkOutput(tag, 32'(sw.state), 32'(expected));
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        edgeNum = 0;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);

        // Reset held for three edges
        stepTo(3);
        checkOutput("rst_clr", 32'(sw.clr), 32'd1);
        checkState("rst_state", 2'b00);
        checkOutput("rst_tick", 32'(sw.tick_en), 32'd0);
        checkOutput("rst_latch", 32'(sw.latch_en), 32'd1);
        checkOutput("rst_leds", 32'({sw.led3, sw.led2, sw.led1, sw.led0}), 32'h8);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        stepTo(4);
        checkOutput("rel_clr", 32'(sw.clr), 32'd0);
        checkState("rel_state", 2'b00);
        checkOutput("rel_led3", 32'(sw.led3), 32'd1);
        checkOutput("rel_latch", 32'(sw.latch_en), 32'd1);

        // Start key low from edge 5 for 12 samples -> RUN at edge 8
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        stepTo(7);
        checkState("start_lat_k2", 2'b00);
        stepTo(8);
        checkState("start_run", 2'b01);
        checkOutput("start_leds", 32'({sw.led3, sw.led2, sw.led1, sw.led0}), 32'h1);
        checkOutput("entry_tick", 32'(sw.tick_en), 32'd0);
        stepTo(12);
        checkOutput("tick1_early", 32'(sw.tick_en), 32'd0);
        stepTo(13);
        checkOutput("tick1", 32'(sw.tick_en), 32'd1);
        stepTo(14);
        checkOutput("tick1_len", 32'(sw.tick_en), 32'd0);
        stepTo(16);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        stepTo(18);
        checkOutput("tick2", 32'(sw.tick_en), 32'd1);

        // Pause press lands on a prescaler wrap: tick kept, PAUSE at edge 23
        stepTo(19);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        stepTo(22);
        checkOutput("wrap_pre_tick", 32'(sw.tick_en), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        stepTo(23);
        checkState("wrap_pause", 2'b10);
        checkOutput("wrap_tick", 32'(sw.tick_en), 32'd1);
        checkOutput("wrap_led1", 32'(sw.led1), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        stepTo(24);
        checkOutput("pause_notick", 32'(sw.tick_en), 32'd0);

        // Re-press 3 cycles into lockout is ignored; press at lockout end resumes
        stepTo(25);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        stepTo(28);
        checkState("lockout_ignored", 2'b10);
        stepTo(29);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        stepTo(32);
        checkState("resume_wait", 2'b10);
        stepTo(33);
        checkState("resume_run", 2'b01);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        stepTo(37);
        checkOutput("resume_tick_early", 32'(sw.tick_en), 32'd0);
        stepTo(38);
        checkOutput("resume_tick", 32'(sw.tick_en), 32'd1);

        // Pause mid-count with prescaler at 4, then resume -> tick one cycle later
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        stepTo(41);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        stepTo(42);
        checkState("mid_pause", 2'b10);
        stepTo(43);
        checkOutput("mid_hold_notick", 32'(sw.tick_en), 32'd0);
        stepTo(47);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        stepTo(50);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        stepTo(51);
        checkState("mid_resume", 2'b01);
        checkOutput("mid_resume_tick0", 32'(sw.tick_en), 32'd0);
        stepTo(52);
        checkOutput("mid_remaining_tick", 32'(sw.tick_en), 32'd1);

        // Display freeze in RUN, ticks continue, second press unfreezes
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        stepTo(55);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        stepTo(56);
        checkOutput("freeze_latch", 32'(sw.latch_en), 32'd0);
        checkOutput("freeze_led2", 32'(sw.led2), 32'd1);
        stepTo(57);
        checkOutput("freeze_tick", 32'(sw.tick_en), 32'd1);
        stepTo(61);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        stepTo(64);
        checkOutput("unfreeze_wait", 32'(sw.latch_en), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        stepTo(65);
        checkOutput("unfreeze_latch", 32'(sw.latch_en), 32'd1);
        checkOutput("unfreeze_led2", 32'(sw.led2), 32'd0);

        // Start key bounce 0-1-0 -> a single RUN->PAUSE change
        stepTo(67);
        checkOutput("pre_bounce_tick", 32'(sw.tick_en), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        stepTo(68);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        stepTo(69);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        stepTo(70);
        checkState("bounce_still_run", 2'b01);
        stepTo(71);
        checkState("bounce_pause", 2'b10);
        stepTo(72);
        checkOutput("bounce_notick", 32'(sw.tick_en), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        stepTo(73);
        checkState("bounce_single", 2'b10);

        // Freeze in PAUSE, then reset key and start key together
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        stepTo(76);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        stepTo(77);
        checkOutput("pause_freeze", 32'(sw.latch_en), 32'd0);
        stepTo(78);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        stepTo(81);
        checkOutput("both_pre_clr", 32'(sw.clr), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        stepTo(82);
        checkState("both_idle", 2'b00);
        checkOutput("both_clr", 32'(sw.clr), 32'd1);
        checkOutput("both_tick", 32'(sw.tick_en), 32'd0);
        checkOutput("both_latch", 32'(sw.latch_en), 32'd1);
        checkOutput("both_leds", 32'({sw.led3, sw.led2, sw.led1, sw.led0}), 32'h8);
        stepTo(83);
        checkOutput("both_clr_once", 32'(sw.clr), 32'd0);
        stepTo(84);
        checkState("both_start_dropped", 2'b00);

        // Display press in IDLE is ignored
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        stepTo(87);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        stepTo(88);
        checkOutput("idle_disp_latch", 32'(sw.latch_en), 32'd1);
        checkOutput("idle_disp_led2", 32'(sw.led2), 32'd0);

        // Run again, then a synchronous reset aborts before the first tick
        stepTo(89);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        stepTo(92);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        stepTo(93);
        checkState("rerun", 2'b01);
        stepTo(95);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        stepTo(96);
        checkState("abort_idle", 2'b00);
        checkOutput("abort_clr", 32'(sw.clr), 32'd1);
        stepTo(97);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        stepTo(98);
        checkOutput("abort_clr_drop", 32'(sw.clr), 32'd0);
        for (int i = 98; i <= 106; i++) begin
            stepTo(i);
            checkOutput("abort_notick", 32'(sw.tick_en), 32'd0);
        end
        checkState("abort_stays_idle", 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter DELAY_TIME, default 10000000, key lockout in clk cycles (200 ms at 50 MHz).
REQ-002 SHALL have parameter TICK_DIV, default 500000, clk cycles per 10 ms tick.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port key_reset  input  1  asynchronous pushbutton, active-low, clears the stopwatch.
REQ-006 SHALL have port key_start_pause  input  1  asynchronous pushbutton, active-low, run/pause toggle.
REQ-007 SHALL have port key_display_stop  input  1  asynchronous pushbutton, active-low, display freeze toggle.
REQ-008 SHALL have port tick_en  output  1  one-cycle pulse that advances the BCD time counters by 10 ms.
REQ-009 SHALL have port clr  output  1  one-cycle pulse that zeroes the BCD time counters.
REQ-010 SHALL have port latch_en  output  1  level; display registers copy the counters while high.
REQ-011 SHALL have port state  output  2  current FSM state: IDLE=00, RUN=01, PAUSE=10.
REQ-012 SHALL have ports led0..led3  output  1 each  status: RUN, PAUSE, frozen, IDLE.

Function
REQ-013 SHALL pass each key through a 2-flop synchroniser, then a falling-edge detector (previous=1, current=0).
REQ-014 SHALL accept an edge only when that key's lockout counter is at or above DELAY_TIME. Acceptance SHALL produce a one-cycle internal press pulse and clear that counter to 0.
REQ-015 SHALL increment each lockout counter every cycle it is below DELAY_TIME, and saturate it at DELAY_TIME.
REQ-016 Latency: key low first sampled at edge k -> press pulse high after edge k+2 -> state/outputs update at edge k+3.
REQ-017 FSM start press transitions: IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
REQ-018 FSM reset-key press: any state->IDLE; clr=1 for exactly one cycle; frozen cleared; prescaler cleared.
REQ-019 Reset-key and start presses in the same cycle: the reset key wins and the start press is discarded.
REQ-020 A display press SHALL toggle the frozen flag in RUN and PAUSE. It SHALL be ignored in IDLE.
REQ-021 latch_en SHALL equal NOT frozen.
REQ-022 Prescaler SHALL be 0..TICK_DIV-1, wrap to 0, count only in RUN, hold its value in PAUSE, and be 0 in IDLE.
REQ-023 tick_en SHALL be 1 exactly when the prescaler is at TICK_DIV-1 in RUN. Period SHALL be TICK_DIV cycles; no tick on the RUN entry cycle.
REQ-024 A start press on the cycle the prescaler wraps SHALL still emit that tick. The next state SHALL be PAUSE with the prescaler at 0.
REQ-025 tick_en and clr SHALL never be high in the same cycle.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 While reset=1, the block SHALL set: state=IDLE, tick_en=0, clr=1, latch_en=1, led0..2=0, led3=1.
REQ-028 While reset=1, the block SHALL clear the prescaler and frozen flag, set synchronisers and previous-key registers to 1, and set lockout counters to DELAY_TIME.
REQ-029 clr SHALL drop to 0 on the first edge after reset deasserts.
REQ-030 A reset during RUN SHALL abort mid-count; no tick SHALL be emitted afterwards until a new start press.

Structure
REQ-031 Package stopwatch_pkg SHALL hold: the state encoding (IDLE/RUN/PAUSE), DELAY_TIME and TICK_DIV defaults, and the lockout counter width (32).
REQ-032 Sub-module key_debounce (synchroniser + edge detector + lockout counter, parameter DELAY_TIME, output press pulse) SHALL be instantiated three times.
REQ-033 The FSM, prescaler and LED decode SHALL live in stopwatch_ctrl; no BCD arithmetic SHALL be done here.

Verification (DELAY_TIME=8, TICK_DIV=5)
REQ-034 Reset 3 cycles, release -> clr high during reset, low on the next cycle; state=00, led3=1, latch_en=1.
REQ-035 Start press, hold 12 cycles -> state=01 at edge k+3; tick_en pulses every 5 cycles; first pulse 5 cycles after RUN entry.
REQ-036 Second start press 3 cycles after the first accepted press -> ignored (lockout); the same press at 10 cycles -> state=10; prescaler holds; resume gives the next tick after the remaining count.
REQ-037 Start key bounce 1-0-1-0 within 4 cycles -> exactly one state change.
REQ-038 Display press in RUN -> latch_en=0, led2=1, ticks continue; a second display press -> latch_en=1; display press in IDLE -> no change.
REQ-039 Reset key and start key pressed on the same cycle in PAUSE -> state=00, one clr pulse, no tick; frozen cleared.
